// File: rtl/mem_stage_lsu_pkg.sv
// mem_stage_lsu_pkg
//   Shared definitions for the MEM-stage load/store unit:
//   - lsu_state_e : bus handshake FSM states
//   - F3_*        : funct3 access size / sign encodings
//   - BE_*        : byte-enable patterns for byte, halfword and word accesses
//   - f3_legal / addr_misaligned : access decode helpers
package mem_stage_lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BE_BYTE    = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    function automatic logic f3_legal(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // funct3[1:0] carries the size for both signed and unsigned variants
    function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic mis;
        case (f3[1:0])
            2'b01:   mis = a[0];
            2'b10:   mis = (a != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// lsu_align
//   Purely combinational lane logic for the load/store unit.
//   Ports:
//     funct3     in  3   access size / sign
//     addr_lo    in  2   byte offset within the word
//     store_data in  32  rs2 value to be written
//     be         out 4   byte enables for the store
//     wdata      out 32  store data replicated across the lanes
//     rdata      in  32  raw bus read word
//     load_data  out 32  selected lane, sign- or zero-extended
module lsu_align
    import mem_stage_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    always_comb begin
        be    = BE_WORD;
        wdata = store_data;
        case (funct3[1:0])
            2'b00: begin
                be    = BE_BYTE << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                be    = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
                wdata = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Move the addressed lane down to bit 0; halfwords are aligned so a
    // byte-granular shift also handles them.
    assign shifted = rdata >> {addr_lo, 3'b000};

    always_comb begin
        load_data = shifted;
        case (funct3)
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   load_data = {24'b0, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   load_data = {16'b0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu
//   MEM pipeline stage: passes ALU results through to MEM/WB and runs a
//   req/gnt + rvalid data-bus handshake for loads and stores.
//   Ports:
//     clk_i, rst_i (async, active low)
//     alu_result_i, store_data_i, mem_read_i, mem_write_i, funct3_i,
//     rd_addr_i, reg_write_i, mem_to_reg_i        EX/MEM inputs
//     stall_o                                     combinational pipeline stall
//     dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
//     dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i     data bus
//     wb_data_o, rd_addr_o, reg_write_o           registered MEM/WB
//     err_o                                       one-cycle error pulse
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] store_data_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        reg_write_i,
    input  logic        mem_to_reg_i,
    output logic        stall_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic [31:0] wb_data_o,
    output logic [4:0]  rd_addr_o,
    output logic        reg_write_o,
    output logic        err_o
);

    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    lsu_state_e state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [31:0] addr_reg, sdata_reg;
    logic [2:0]  f3_reg;
    logic        we_reg, rw_reg, m2r_reg;
    logic [4:0]  rd_reg;

    logic        mem_op, bad_op, start, timeout;
    logic        load_done, tmo_evt;
    logic [3:0]  be_raw;
    logic [31:0] load_data;

    assign mem_op  = mem_read_i | mem_write_i;
    assign bad_op  = (mem_read_i & mem_write_i) |
                     (mem_op & (!f3_legal(funct3_i) |
                                addr_misaligned(funct3_i, alu_result_i[1:0])));
    assign start   = mem_op & !bad_op;
    // cnt_reg counts cycles already spent in REQ/RESP; this is the last allowed one
    assign timeout = (cnt_reg == CNT_W'(WAIT_MAX - 1));

    lsu_align u_align (
        .funct3     (f3_reg),
        .addr_lo    (addr_reg[1:0]),
        .store_data (sdata_reg),
        .be         (be_raw),
        .wdata      (dmem_wdata_o),
        .rdata      (dmem_rdata_i),
        .load_data  (load_data)
    );

    assign dmem_req_o  = (state_reg == ST_REQ);
    assign dmem_we_o   = dmem_req_o & we_reg;
    assign dmem_addr_o = {addr_reg[31:2], 2'b00};
    assign dmem_be_o   = dmem_req_o ? be_raw : 4'b0000;

    always_comb begin
        state_next = state_reg;
        stall_o    = 1'b0;
        load_done  = 1'b0;
        tmo_evt    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    stall_o    = 1'b1;
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                // A completing store wins over a timeout in the same cycle
                if (dmem_gnt_i && we_reg) begin
                    state_next = ST_IDLE;
                end else if (timeout) begin
                    tmo_evt    = 1'b1;
                    state_next = ST_IDLE;
                end else if (dmem_gnt_i) begin
                    stall_o    = 1'b1;
                    state_next = ST_RESP;
                end else begin
                    stall_o    = 1'b1;
                end
            end
            ST_RESP: begin
                if (dmem_rvalid_i) begin
                    load_done  = 1'b1;
                    state_next = ST_IDLE;
                end else if (timeout) begin
                    tmo_evt    = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    stall_o    = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            addr_reg    <= '0;
            sdata_reg   <= '0;
            f3_reg      <= '0;
            we_reg      <= 1'b0;
            rw_reg      <= 1'b0;
            m2r_reg     <= 1'b0;
            rd_reg      <= '0;
            wb_data_o   <= '0;
            rd_addr_o   <= '0;
            reg_write_o <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            state_reg   <= state_next;
            err_o       <= 1'b0;
            reg_write_o <= 1'b0;
            if (state_reg == ST_IDLE) begin
                cnt_reg <= '0;
                if (start) begin
                    addr_reg  <= alu_result_i;
                    sdata_reg <= store_data_i;
                    f3_reg    <= funct3_i;
                    we_reg    <= mem_write_i;
                    rw_reg    <= reg_write_i;
                    m2r_reg   <= mem_to_reg_i;
                    rd_reg    <= rd_addr_i;
                end else if (bad_op) begin
                    err_o <= 1'b1;
                end else begin
                    wb_data_o   <= alu_result_i;
                    rd_addr_o   <= rd_addr_i;
                    reg_write_o <= reg_write_i;
                end
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
                if (tmo_evt) begin
                    err_o <= 1'b1;
                end
                if (load_done) begin
                    wb_data_o   <= m2r_reg ? load_data : addr_reg;
                    rd_addr_o   <= rd_reg;
                    reg_write_o <= rw_reg;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

    localparam int WAIT_MAX = 8;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] alu_result_i = '0;
    logic [31:0] store_data_i = '0;
    logic        mem_read_i = 1'b0;
    logic        mem_write_i = 1'b0;
    logic [2:0]  funct3_i = '0;
    logic [4:0]  rd_addr_i = '0;
    logic        reg_write_i = 1'b0;
    logic        mem_to_reg_i = 1'b0;
    logic        stall_o;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i = 1'b0;
    logic        dmem_rvalid_i = 1'b0;
    logic [31:0] dmem_rdata_i = '0;
    logic [31:0] wb_data_o;
    logic [4:0]  rd_addr_o;
    logic        reg_write_o;
    logic        err_o;

    mem_stage_lsu #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .alu_result_i  (alu_result_i),
        .store_data_i  (store_data_i),
        .mem_read_i    (mem_read_i),
        .mem_write_i   (mem_write_i),
        .funct3_i      (funct3_i),
        .rd_addr_i     (rd_addr_i),
        .reg_write_i   (reg_write_i),
        .mem_to_reg_i  (mem_to_reg_i),
        .stall_o       (stall_o),
        .dmem_req_o    (dmem_req_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_be_o     (dmem_be_o),
        .dmem_wdata_o  (dmem_wdata_o),
        .dmem_gnt_i    (dmem_gnt_i),
        .dmem_rvalid_i (dmem_rvalid_i),
        .dmem_rdata_i  (dmem_rdata_i),
        .wb_data_o     (wb_data_o),
        .rd_addr_o     (rd_addr_o),
        .reg_write_o   (reg_write_o),
        .err_o         (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        err;
        logic [31:0] data;
        logic [4:0]  rd;
    } wb_exp_t;

    wb_exp_t exp_q[$];
    wb_exp_t mon_e;
    int checks = 0;
    int failures = 0;

    // Scoreboard: every register write or error pulse must match the head of the queue
    always @(negedge clk_i) begin
        if (reg_write_o === 1'b1 || err_o === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL wb_unexpected: reg_write_o=%0b err_o=%0b wb_data_o=%h rd=%0d, required no event",
                         reg_write_o, err_o, wb_data_o, rd_addr_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.err) begin
                    if (err_o !== 1'b1 || reg_write_o !== 1'b0) begin
                        failures++;
                        $display("FAIL wb_err_event: err_o=%0b reg_write_o=%0b, required err_o=1 reg_write_o=0",
                                 err_o, reg_write_o);
                    end else
                        $display("t=%0t err pulse", $time);
                end else begin
                    if (err_o !== 1'b0 || reg_write_o !== 1'b1 ||
                        wb_data_o !== mon_e.data || rd_addr_o !== mon_e.rd) begin
                        failures++;
                        $display("FAIL wb_write_event: err=%0b rw=%0b data=%h rd=%0d, required err=0 rw=1 data=%h rd=%0d",
                                 err_o, reg_write_o, wb_data_o, rd_addr_o, mon_e.data, mon_e.rd);
                    end else
                        $display("t=%0t writeback rd=%0d data=%h", $time, rd_addr_o, wb_data_o);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic set_nop();
        alu_result_i = '0; store_data_i = '0; mem_read_i = 1'b0; mem_write_i = 1'b0;
        funct3_i = '0; rd_addr_i = '0; reg_write_i = 1'b0; mem_to_reg_i = 1'b0;
    endtask

    task automatic push_wb(input logic [31:0] data, input logic [4:0] rd);
        wb_exp_t e;
        e.err = 1'b0; e.data = data; e.rd = rd;
        exp_q.push_back(e);
    endtask

    task automatic push_err();
        wb_exp_t e;
        e.err = 1'b1; e.data = '0; e.rd = '0;
        exp_q.push_back(e);
    endtask

    // Drives one memory access and plays the bus slave; reports what it saw.
    // rv_dly < 0 means rvalid is never returned.
    task automatic mem_access(input logic [31:0] addr, input logic [2:0] f3, input logic is_store,
                              input logic [31:0] sdata, input logic [31:0] rdata,
                              input int gnt_dly, input int rv_dly, input logic [4:0] rd, input logic rw,
                              output int stall_cyc, output int req_cyc, output logic [31:0] addr_seen,
                              output logic [3:0] be_seen, output logic [31:0] wdata_seen,
                              output logic we_seen, output bit finished);
        int  reqs_waited = 0;
        int  rv_wait = 0;
        bit  granted = 0;
        bit  gnt_now;
        stall_cyc = 0; req_cyc = 0; finished = 0;
        addr_seen = '0; be_seen = '0; wdata_seen = '0; we_seen = 1'b0;
        alu_result_i = addr; store_data_i = sdata; mem_read_i = !is_store; mem_write_i = is_store;
        funct3_i = f3; rd_addr_i = rd; reg_write_i = rw; mem_to_reg_i = !is_store;
        for (int cyc = 0; cyc < 40 && !finished; cyc++) begin
            gnt_now       = dmem_req_o && (reqs_waited == gnt_dly);
            dmem_gnt_i    = gnt_now;
            dmem_rvalid_i = granted && (rv_dly >= 0) && (rv_wait == rv_dly);
            dmem_rdata_i  = dmem_rvalid_i ? rdata : 32'h0;
            @(negedge clk_i);
            if (dmem_req_o) begin
                if (req_cyc == 0) begin
                    addr_seen = dmem_addr_o; be_seen = dmem_be_o;
                    wdata_seen = dmem_wdata_o; we_seen = dmem_we_o;
                end
                req_cyc++;
            end
            if (stall_o) stall_cyc++;
            else finished = 1;
            @(posedge clk_i); #1;
            if (gnt_now) granted = 1;
            else if (granted) rv_wait++;
            if (dmem_gnt_i == 1'b0 && req_cyc > 0 && !granted) reqs_waited = req_cyc;
        end
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
        set_nop();
    endtask

    task automatic test_reset();
        set_nop();
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        checks++;
        if (dmem_req_o !== 1'b0 || stall_o !== 1'b0 || reg_write_o !== 1'b0 || err_o !== 1'b0 ||
            wb_data_o !== 32'h0 || rd_addr_o !== 5'd0) begin
            failures++;
            $display("FAIL reset_state: req=%0b stall=%0b rw=%0b err=%0b wb=%h rd=%0d, required all 0",
                     dmem_req_o, stall_o, reg_write_o, err_o, wb_data_o, rd_addr_o);
        end
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
    endtask

    task automatic test_alu();
        alu_result_i = 32'h0000_1234; rd_addr_i = 5'd5; reg_write_i = 1'b1;
        push_wb(32'h0000_1234, 5'd5);
        @(negedge clk_i);
        checks++;
        if (stall_o !== 1'b0) begin
            failures++;
            $display("FAIL alu_stall: stall_o=%0b, required 0", stall_o);
        end
        @(posedge clk_i); #1;
        set_nop();
        @(negedge clk_i);
        checks++;
        if (stall_o !== 1'b0 || wb_data_o !== 32'h0000_1234 || reg_write_o !== 1'b1) begin
            failures++;
            $display("FAIL alu_result: stall=%0b wb=%h rw=%0b, required stall=0 wb=00001234 rw=1",
                     stall_o, wb_data_o, reg_write_o);
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4] = '{32'hDEAD_0001, 32'h0000_0000, 32'hFFFF_FFFF, 32'h1357_9BDF};
        logic        rws  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        int stalls = 0;
        for (int i = 0; i < 4; i++) begin
            alu_result_i = vals[i]; rd_addr_i = 5'(i + 10); reg_write_i = rws[i];
            if (rws[i]) push_wb(vals[i], 5'(i + 10));
            @(negedge clk_i);
            if (stall_o) stalls++;
            @(posedge clk_i); #1;
        end
        set_nop();
        checks++;
        if (stalls != 0) begin
            failures++;
            $display("FAIL b2b_stall: stall cycles=%0d, required 0", stalls);
        end
    endtask

    task automatic test_loads();
        logic [31:0] addrs [6] = '{32'h103, 32'h101, 32'h102, 32'h102, 32'h100, 32'h104};
        logic [2:0]  f3s   [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b001, 3'b010};
        logic [31:0] rds   [6] = '{32'h80FF_FFFF, 32'h1234_5678, 32'h8001_7FFF, 32'h8001_7FFF,
                                   32'h0000_F00F, 32'hDEAD_BEEF};
        logic [31:0] exps  [6] = '{32'hFFFF_FF80, 32'h0000_0056, 32'hFFFF_8001, 32'h0000_8001,
                                   32'hFFFF_F00F, 32'hDEAD_BEEF};
        int          gd    [6] = '{0, 1, 0, 2, 0, 2};
        int          rv    [6] = '{0, 0, 1, 0, 2, 1};
        int sc, rc; logic [31:0] a, wd; logic [3:0] b; logic we; bit fin;
        for (int i = 0; i < 6; i++) begin
            push_wb(exps[i], 5'(i + 1));
            mem_access(addrs[i], f3s[i], 1'b0, 32'h0, rds[i], gd[i], rv[i], 5'(i + 1), 1'b1,
                       sc, rc, a, b, wd, we, fin);
            checks++;
            if (!fin || sc != 2 + gd[i] + rv[i] || rc != gd[i] + 1 ||
                a !== (addrs[i] & 32'hFFFF_FFFC) || we !== 1'b0) begin
                failures++;
                $display("FAIL load_%0d: done=%0b stall=%0d req=%0d addr=%h we=%0b, required done=1 stall=%0d req=%0d addr=%h we=0",
                         i, fin, sc, rc, a, we, 2 + gd[i] + rv[i], gd[i] + 1, addrs[i] & 32'hFFFF_FFFC);
            end
        end
    endtask

    task automatic test_stores();
        logic [31:0] addrs [3] = '{32'h202, 32'h201, 32'h204};
        logic [2:0]  f3s   [3] = '{3'b001, 3'b000, 3'b010};
        logic [31:0] sds   [3] = '{32'h0000_ABCD, 32'h0000_00EF, 32'h1234_5678};
        logic [3:0]  ebes  [3] = '{4'b1100, 4'b0010, 4'b1111};
        logic [31:0] ewds  [3] = '{32'hABCD_ABCD, 32'hEFEF_EFEF, 32'h1234_5678};
        int          gd    [3] = '{3, 0, 1};
        int sc, rc; logic [31:0] a, wd; logic [3:0] b; logic we; bit fin;
        for (int i = 0; i < 3; i++) begin
            mem_access(addrs[i], f3s[i], 1'b1, sds[i], 32'h0, gd[i], 0, 5'(i + 20), 1'b1,
                       sc, rc, a, b, wd, we, fin);
            checks++;
            if (!fin || sc != 1 + gd[i] || rc != gd[i] + 1 || b !== ebes[i] || wd !== ewds[i] ||
                we !== 1'b1 || a !== (addrs[i] & 32'hFFFF_FFFC)) begin
                failures++;
                $display("FAIL store_%0d: done=%0b stall=%0d req=%0d be=%b wdata=%h we=%0b addr=%h, required done=1 stall=%0d req=%0d be=%b wdata=%h we=1",
                         i, fin, sc, rc, b, wd, we, a, 1 + gd[i], gd[i] + 1, ebes[i], ewds[i]);
            end
        end
        @(negedge clk_i);
        checks++;
        if (reg_write_o !== 1'b0) begin
            failures++;
            $display("FAIL store_no_wb: reg_write_o=%0b, required 0", reg_write_o);
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_errors();
        logic [31:0] addrs [6] = '{32'h101, 32'h103, 32'h201, 32'h100, 32'h100, 32'h100};
        logic [2:0]  f3s   [6] = '{3'b010, 3'b001, 3'b001, 3'b011, 3'b010, 3'b110};
        logic        rdq   [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic        wrq   [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            alu_result_i = addrs[i]; funct3_i = f3s[i]; mem_read_i = rdq[i]; mem_write_i = wrq[i];
            rd_addr_i = 5'd7; reg_write_i = rdq[i]; mem_to_reg_i = rdq[i];
            push_err();
            @(negedge clk_i);
            checks++;
            if (stall_o !== 1'b0 || dmem_req_o !== 1'b0) begin
                failures++;
                $display("FAIL err_%0d_issue: stall=%0b req=%0b, required 0 0", i, stall_o, dmem_req_o);
            end
            @(posedge clk_i); #1;
            set_nop();
            @(negedge clk_i);
            checks++;
            if (dmem_req_o !== 1'b0 || err_o !== 1'b1) begin
                failures++;
                $display("FAIL err_%0d_pulse: req=%0b err=%0b, required req=0 err=1", i, dmem_req_o, err_o);
            end
            @(posedge clk_i); #1;
        end
    endtask

    task automatic test_timeout();
        int sc, rc; logic [31:0] a, wd; logic [3:0] b; logic we; bit fin;
        push_err();
        mem_access(32'h400, 3'b010, 1'b0, 32'h0, 32'h0, 0, -1, 5'd4, 1'b1,
                   sc, rc, a, b, wd, we, fin);
        checks++;
        if (!fin || sc != WAIT_MAX || rc != 1) begin
            failures++;
            $display("FAIL timeout: done=%0b stall=%0d req=%0d, required done=1 stall=%0d req=1",
                     fin, sc, rc, WAIT_MAX);
        end
        @(negedge clk_i);
        checks++;
        if (err_o !== 1'b1 || stall_o !== 1'b0 || dmem_req_o !== 1'b0) begin
            failures++;
            $display("FAIL timeout_idle: err=%0b stall=%0b req=%0b, required 1 0 0", err_o, stall_o, dmem_req_o);
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset_mid();
        // Reset while the request is outstanding
        alu_result_i = 32'h500; funct3_i = 3'b010; mem_read_i = 1'b1; rd_addr_i = 5'd9;
        reg_write_i = 1'b1; mem_to_reg_i = 1'b1;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        checks++;
        if (dmem_req_o !== 1'b1) begin
            failures++;
            $display("FAIL rstreq_pre: req=%0b, required 1", dmem_req_o);
        end
        #2; set_nop(); rst_i = 1'b0;
        #1;
        checks++;
        if (dmem_req_o !== 1'b0 || stall_o !== 1'b0) begin
            failures++;
            $display("FAIL rstreq_async: req=%0b stall=%0b, required 0 0", dmem_req_o, stall_o);
        end
        @(posedge clk_i); #1; rst_i = 1'b1;
        // Reset while waiting for the response
        alu_result_i = 32'h504; funct3_i = 3'b010; mem_read_i = 1'b1; rd_addr_i = 5'd9;
        reg_write_i = 1'b1; mem_to_reg_i = 1'b1;
        @(posedge clk_i); #1; dmem_gnt_i = 1'b1;
        @(posedge clk_i); #1; dmem_gnt_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (stall_o !== 1'b1 || dmem_req_o !== 1'b0) begin
            failures++;
            $display("FAIL rstresp_pre: stall=%0b req=%0b, required 1 0", stall_o, dmem_req_o);
        end
        #2; set_nop(); rst_i = 1'b0;
        #1;
        checks++;
        if (dmem_req_o !== 1'b0 || stall_o !== 1'b0 || reg_write_o !== 1'b0) begin
            failures++;
            $display("FAIL rstresp_async: req=%0b stall=%0b rw=%0b, required 0 0 0", dmem_req_o, stall_o, reg_write_o);
        end
        @(posedge clk_i); #1; rst_i = 1'b1;
        // Late response after reset must be ignored
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h5555_AAAA;
        repeat (2) begin
            @(negedge clk_i);
            checks++;
            if (stall_o !== 1'b0 || dmem_req_o !== 1'b0) begin
                failures++;
                $display("FAIL late_rvalid: stall=%0b req=%0b, required 0 0", stall_o, dmem_req_o);
            end
            @(posedge clk_i); #1;
        end
        dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
        alu_result_i = 32'h0000_CAFE; rd_addr_i = 5'd3; reg_write_i = 1'b1;
        push_wb(32'h0000_CAFE, 5'd3);
        @(posedge clk_i); #1;
        set_nop();
        @(negedge clk_i);
        checks++;
        if (wb_data_o !== 32'h0000_CAFE || rd_addr_o !== 5'd3 || reg_write_o !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_alu: wb=%h rd=%0d rw=%0b, required 0000cafe 3 1", wb_data_o, rd_addr_o, reg_write_o);
        end
        @(posedge clk_i); #1;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_loads();
        test_stores();
        test_errors();
        test_timeout();
        test_reset_mid();
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: pending=%0d, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 Parameter: WAIT_MAX, 255, maximum cycles spent in REQ plus RESP before a bus timeout.
REQ-002 Port: clk_i  in  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst_i  in  1  asynchronous, active-low reset.
REQ-004 Port: alu_result_i  in  32  EX/MEM ALU result; byte address for loads and stores.
REQ-005 Port: store_data_i  in  32  rs2 value for stores.
REQ-006 Port: mem_read_i, mem_write_i  in  1 each  load / store qualifiers; both high together is illegal.
REQ-007 Port: funct3_i  in  3  access size and sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-008 Port: rd_addr_i  in  5; reg_write_i  in  1; mem_to_reg_i  in  1  writeback controls.
REQ-009 Port: stall_o  out  1  combinational; upstream holds all inputs stable while high.
REQ-010 Port: dmem_req_o, dmem_we_o  out  1 each; dmem_addr_o  out  32, word aligned (bits 1:0 = 0); dmem_be_o  out  4; dmem_wdata_o  out  32.
REQ-011 Port: dmem_gnt_i, dmem_rvalid_i  in  1 each; dmem_rdata_i  in  32.
REQ-012 Port: wb_data_o  out  32; rd_addr_o  out  5; reg_write_o  out  1  registered MEM/WB outputs.
REQ-013 Port: err_o  out  1  registered one-cycle pulse on misaligned, illegal or timed-out access.

Function
REQ-014 FSM states: IDLE, REQ, RESP; inputs are sampled only in IDLE; the accepted access (address, size, write data, rd, controls) is latched on leaving IDLE.
REQ-015 Non-memory op in IDLE (both qualifiers low): stall_o = 0; next edge wb_data_o = alu_result_i, rd_addr_o = rd_addr_i, reg_write_o = reg_write_i (1-cycle latency).
REQ-016 Legal memory op in IDLE: stall_o = 1; next edge go to REQ with dmem_req_o = 1, held until dmem_gnt_i.
REQ-017 REQ, store: dmem_gnt_i = 1 -> IDLE, drop request; stall_o = 0 in that cycle.
REQ-018 REQ, load: dmem_gnt_i = 1 -> RESP; RESP: dmem_rvalid_i = 1 -> IDLE with stall_o = 0 in that cycle; WB registers capture the extended load data on that edge.
REQ-019 stall_o = (IDLE & memory op) | (REQ & !(gnt & we)) | (RESP & !rvalid); while stall_o = 1, reg_write_o is registered as 0 (bubble).
REQ-020 rvalid is honoured only in RESP; rvalid during REQ or IDLE is ignored.
REQ-021 Byte enables: SB 1<<addr[1:0], data byte replicated to all lanes; SH addr[1]=0 -> 0011, else 1100, halfword replicated; SW 1111.
REQ-022 Loads: extract the lane selected by addr[1:0]; LB/LH sign-extend; LBU/LHU zero-extend.
REQ-023 Misaligned (halfword addr[0]=1; word addr[1:0]!=0) or illegal (funct3 011/110/111, or both qualifiers high): no bus request; err_o pulses; reg_write_o = 0; stall_o = 0.
REQ-024 Timeout: counter cleared on leaving IDLE; reaching WAIT_MAX in REQ/RESP -> IDLE; err_o pulses; reg_write_o = 0; stall_o = 0 in that cycle.

Reset
REQ-025 rst_i low: state IDLE, dmem_req_o = 0 immediately (asynchronously); counter, wb_data_o, rd_addr_o, reg_write_o, err_o = 0.
REQ-026 Reset during REQ/RESP abandons the access; a late rvalid after reset release is ignored.

Structure
REQ-027 Shared package: FSM state enum, funct3 size/sign encodings, and the be/extension constants.
REQ-028 One sub-module, lsu_align: combinational be/wdata generation and load lane extraction/extension.

Verification
REQ-029 ADD result 0x0000_1234, rd=5, reg_write=1 -> next cycle wb_data_o=0x1234, rd_addr_o=5, reg_write_o=1, stall_o never high.
REQ-030 LB addr 0x103, gnt in first REQ cycle, rvalid next cycle with rdata 0x80FF_FFFF -> wb_data_o=0xFFFF_FF80, dmem_addr_o=0x100, stall high exactly 2 cycles.
REQ-031 SH addr 0x202, data 0x0000_ABCD, gnt delayed 3 cycles -> be=1100, wdata=0xABCD_ABCD, req held 4 cycles, no writeback.
REQ-032 LW addr 0x101 -> no dmem_req_o, err_o one pulse, reg_write_o=0, stall_o=0.
REQ-033 WAIT_MAX=8, load granted, rvalid never -> err_o pulse after 8 cycles, return to IDLE, no register write.
REQ-034 rst_i low during RESP -> dmem_req_o=0 and IDLE at once; rvalid after release ignored; next ADD completes normally.
